// File: rtl/fp_elem_stream_loader.sv
// Streaming loader/readback engine for the wide extension-field coefficient RAM.
// Lanes are assembled into one element per RAM write; reads are serialised lane by lane.
module fp_elem_stream_loader #(
    parameter int WORD_SIZE    = 510,
    parameter int LANES        = 24,
    parameter int ADDR_SIZE    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WORD_SIZE-1:0]         s_data,
    input  logic [ADDR_SIZE-1:0]         s_addr,
    input  logic                         s_last,
    input  logic                         rd_req_valid,
    output logic                         rd_req_ready,
    input  logic [ADDR_SIZE-1:0]         rd_req_addr,
    output logic                         ram_we,
    output logic [ADDR_SIZE-1:0]         ram_waddr,
    output logic [LANES*WORD_SIZE-1:0]   ram_wdata,
    output logic                         ram_re,
    output logic [ADDR_SIZE-1:0]         ram_raddr,
    input  logic [LANES*WORD_SIZE-1:0]   ram_rdata,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WORD_SIZE-1:0]         m_data,
    output logic [$clog2(LANES)-1:0]     m_lane,
    output logic                         m_last,
    output logic                         busy,
    output logic                         err
);

    localparam int LCW = $clog2(LANES);
    localparam int WCW = $clog2(READ_LATENCY + 1);
    localparam logic [LCW-1:0] LAST_LANE = LCW'(LANES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RD_ISSUE, RD_WAIT, DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [LCW-1:0]                  lane_cnt_q, lane_cnt_d;
    logic [WCW-1:0]                  wait_q, wait_d;
    logic                            err_q, err_d;
    logic [ADDR_SIZE-1:0]            addr_q, waddr_q, raddr_q;
    logic [LANES-2:0][WORD_SIZE-1:0] abuf_q;
    logic [LANES-1:0][WORD_SIZE-1:0] wdata_q, obuf_q;
    logic                            store_lane, latch_waddr, latch_raddr, commit, capture;
    logic                            s_ready_c, rd_req_ready_c, m_valid_c;

    always_comb begin
        state_d        = state_q;
        lane_cnt_d     = lane_cnt_q;
        wait_d         = wait_q;
        err_d          = 1'b0;
        s_ready_c      = 1'b0;
        rd_req_ready_c = 1'b0;
        m_valid_c      = 1'b0;
        store_lane     = 1'b0;
        latch_waddr    = 1'b0;
        latch_raddr    = 1'b0;
        commit         = 1'b0;
        capture        = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready_c      = 1'b1;
                rd_req_ready_c = !s_valid;
                lane_cnt_d     = '0;
                if (s_valid) begin
                    store_lane  = 1'b1;
                    latch_waddr = 1'b1;
                    if (s_last) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = LOAD;
                        lane_cnt_d = LCW'(1);
                    end
                end else if (rd_req_valid) begin
                    latch_raddr = 1'b1;
                    state_d     = RD_ISSUE;
                end
            end
            LOAD: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    // An element is only committed when s_last lands exactly on the final lane.
                    if (lane_cnt_q == LAST_LANE) begin
                        lane_cnt_d = '0;
                        if (s_last) begin
                            commit  = 1'b1;
                            state_d = WRITE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (s_last) begin
                        err_d      = 1'b1;
                        lane_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        store_lane = 1'b1;
                        lane_cnt_d = lane_cnt_q + LCW'(1);
                    end
                end
            end
            WRITE: state_d = IDLE;
            RD_ISSUE: begin
                wait_d  = WCW'(READ_LATENCY);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (wait_q == WCW'(1)) begin
                    capture    = 1'b1;
                    lane_cnt_d = '0;
                    state_d    = DRAIN;
                end else begin
                    wait_d = wait_q - WCW'(1);
                end
            end
            DRAIN: begin
                m_valid_c = 1'b1;
                if (m_ready) begin
                    if (lane_cnt_q == LAST_LANE) begin
                        lane_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        lane_cnt_d = lane_cnt_q + LCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            abuf_q     <= '0;
            wdata_q    <= '0;
            obuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            if (store_lane)  abuf_q[lane_cnt_q] <= s_data;
            if (latch_waddr) addr_q <= s_addr;
            if (latch_raddr) raddr_q <= rd_req_addr;
            if (commit) begin
                wdata_q <= {s_data, abuf_q};
                waddr_q <= addr_q;
            end
            if (capture) obuf_q <= ram_rdata;
        end
    end

    // Outputs are forced low combinationally so they read zero for the whole reset period.
    assign s_ready      = s_ready_c && !rst;
    assign rd_req_ready = rd_req_ready_c && !rst;
    assign m_valid      = m_valid_c && !rst;
    assign ram_we       = (state_q == WRITE) && !rst;
    assign ram_re       = (state_q == RD_ISSUE) && !rst;
    assign busy         = (state_q != IDLE) && !rst;
    assign err          = err_q && !rst;
    assign ram_waddr    = rst ? '0 : waddr_q;
    assign ram_raddr    = rst ? '0 : raddr_q;
    assign ram_wdata    = rst ? '0 : wdata_q;
    assign m_data       = rst ? '0 : obuf_q[lane_cnt_q];
    assign m_lane       = rst ? '0 : lane_cnt_q;
    assign m_last       = m_valid && (lane_cnt_q == LAST_LANE);

endmodule

// File: tb/tb_fp_elem_stream_loader.sv
// Bench for fp_elem_stream_loader: random elements are loaded, read back through a RAM model
// and compared against a lane-array reference memory kept here.
module tb_fp_elem_stream_loader;
    localparam int W   = 510;
    localparam int L   = 24;
    localparam int A   = 8;
    localparam int RL  = 2;
    localparam int LCW = $clog2(L);
    localparam int L2  = 12;
    localparam int LCW2 = $clog2(L2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic s_valid, s_ready, s_last, rd_req_valid, rd_req_ready;
    logic ram_we, ram_re, m_valid, m_ready, m_last, busy, err;
    logic [W-1:0] s_data, m_data;
    logic [A-1:0] s_addr, rd_req_addr, ram_waddr, ram_raddr;
    logic [L*W-1:0] ram_wdata, ram_rdata;
    logic [LCW-1:0] m_lane;

    logic b_s_valid, b_s_ready, b_s_last, b_rd_req_ready, b_ram_we, b_ram_re;
    logic b_m_valid, b_m_last, b_busy, b_err;
    logic [W-1:0] b_s_data, b_m_data;
    logic [A-1:0] b_s_addr, b_ram_waddr, b_ram_raddr;
    logic [L2*W-1:0] b_ram_wdata;
    logic [L2*W-1:0] b_ram_rdata = '0;
    logic [LCW2-1:0] b_m_lane;

    fp_elem_stream_loader #(.WORD_SIZE(W), .LANES(L), .ADDR_SIZE(A), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_addr(s_addr), .s_last(s_last), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_lane(m_lane), .m_last(m_last), .busy(busy), .err(err)
    );

    fp_elem_stream_loader #(.WORD_SIZE(W), .LANES(L2), .ADDR_SIZE(A), .READ_LATENCY(RL)) dut12 (
        .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .s_addr(b_s_addr), .s_last(b_s_last), .rd_req_valid(1'b0),
        .rd_req_ready(b_rd_req_ready), .rd_req_addr(8'h00), .ram_we(b_ram_we),
        .ram_waddr(b_ram_waddr), .ram_wdata(b_ram_wdata), .ram_re(b_ram_re),
        .ram_raddr(b_ram_raddr), .ram_rdata(b_ram_rdata), .m_valid(b_m_valid), .m_ready(1'b0),
        .m_data(b_m_data), .m_lane(b_m_lane), .m_last(b_m_last), .busy(b_busy), .err(b_err)
    );

    // RAM model: data is presented only in the single cycle READ_LATENCY after ram_re.
    logic [L*W-1:0] ram [256];
    logic [L*W-1:0] rdPipe [RL];
    always @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        rdPipe[0] <= ram_re ? ram[ram_raddr] : '1;
        for (int i = 1; i < RL; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign ram_rdata = rdPipe[RL-1];

    int cyc = 0, weCount = 0, errCount = 0, rdLeak = 0;
    bit watchRd = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ram_we) weCount <= weCount + 1;
        if (err) errCount <= errCount + 1;
        if (watchRd && rd_req_ready) rdLeak <= rdLeak + 1;
    end

    int total = 0, bad = 0;
    logic [W-1:0] elem [L];
    logic [W-1:0] refMem [256][L];

    function automatic logic [W-1:0] rand_word();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    task automatic fill_elem(input bit incr);
        for (int k = 0; k < L; k++) elem[k] = incr ? W'(k + 1) : rand_word();
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took the last beat.
    task automatic drive_beats(input logic [A-1:0] addr, input int lastPos, input int nBeats,
                               output bit ok, output int firstAcc, output int lastAcc);
        bit acc;
        int guard;
        ok = 1'b1; firstAcc = -1; lastAcc = -1;
        for (int i = 0; i < nBeats; i++) begin
            s_valid = 1'b1;
            s_data  = elem[i];
            s_addr  = (i == 0) ? addr : A'($urandom);
            s_last  = (i == lastPos);
            guard   = 0;
            do begin
                @(negedge clk); acc = s_ready;
                @(posedge clk); #1; guard++;
            end while (!acc && guard < 20);
            if (!acc) begin ok = 1'b0; break; end
            if (i == 0) firstAcc = cyc;
            lastAcc = cyc;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; rd_req_valid = 1'b1; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({s_ready, rd_req_ready, ram_we, ram_re, m_valid, m_last, busy, err} !== 8'h00) begin
            bad++; $display("[TB] FAIL reset_ctrl: got %b want 00000000",
                {s_ready, rd_req_ready, ram_we, ram_re, m_valid, m_last, busy, err});
        end
        total++;
        if (m_data !== '0 || m_lane !== '0 || ram_waddr !== '0 || ram_raddr !== '0) begin
            bad++; $display("[TB] FAIL reset_data: got lane=%0d waddr=%0h raddr=%0h want all 0",
                m_lane, ram_waddr, ram_raddr);
        end
        total++;
        if (ram_wdata !== '0) begin bad++; $display("[TB] FAIL reset_wdata: got nonzero want 0"); end
        @(posedge clk); #1;
        rst = 1'b0; rd_req_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({s_ready, rd_req_ready, busy, err} !== 4'b1100) begin
            bad++; $display("[TB] FAIL post_reset: got %b want 1100", {s_ready, rd_req_ready, busy, err});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load(input logic [A-1:0] addr, input bit incr);
        bit ok; int f, l, weBefore, badLanes;
        fill_elem(incr);
        weBefore = weCount;
        drive_beats(addr, L-1, L, ok, f, l);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL load_accept: got timeout want %0d beats", L); end
        total++;
        if (l - f !== L - 1) begin bad++; $display("[TB] FAIL load_rate: got %0d want %0d", l - f, L - 1); end
        @(negedge clk);
        total++;
        if (ram_we !== 1'b1 || s_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL load_we: got we=%b s_ready=%b want 1 0", ram_we, s_ready);
        end
        total++;
        if (ram_waddr !== addr) begin bad++; $display("[TB] FAIL load_waddr: got %0h want %0h", ram_waddr, addr); end
        badLanes = 0;
        for (int k = 0; k < L; k++) if (ram_wdata[k*W +: W] !== elem[k]) badLanes++;
        total++;
        if (badLanes != 0) begin bad++; $display("[TB] FAIL load_wdata: got %0d bad lanes want 0", badLanes); end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (ram_we !== 1'b0) begin bad++; $display("[TB] FAIL load_we_pulse: got %b want 0", ram_we); end
        @(posedge clk); #1;
        total++;
        if (weCount - weBefore !== 1) begin
            bad++; $display("[TB] FAIL load_we_count: got %0d want 1", weCount - weBefore);
        end
        for (int k = 0; k < L; k++) refMem[addr][k] = elem[k];
    endtask

    // mode 0: m_ready always high, 1: pattern 1,0,0,1, 2: random
    task automatic test_readback(input logic [A-1:0] addr, input int mode);
        bit acc, held;
        int guard, k, expLane, firstValid;
        logic [W-1:0] hd;
        logic [LCW-1:0] hl;
        rd_req_valid = 1'b1; rd_req_addr = addr; guard = 0;
        do begin
            @(negedge clk); acc = rd_req_ready;
            @(posedge clk); #1; guard++;
        end while (!acc && guard < 50);
        rd_req_valid = 1'b0; rd_req_addr = A'($urandom);
        total++;
        if (!acc) begin bad++; $display("[TB] FAIL rd_req_accept: got timeout want handshake"); return; end
        k = 0; expLane = 0; firstValid = -1; held = 1'b0; hd = '0; hl = '0;
        while (expLane < L && k < 400) begin
            k++;
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (ram_re !== 1'b1 || ram_raddr !== addr) begin
                    bad++; $display("[TB] FAIL rd_issue: got re=%b raddr=%0h want 1 %0h", ram_re, ram_raddr, addr);
                end
            end
            if (m_valid && firstValid < 0) firstValid = k;
            if (held) begin
                total++;
                if (m_data !== hd || m_lane !== hl) begin
                    bad++; $display("[TB] FAIL rd_stall_hold: got lane %0d want lane %0d unchanged", m_lane, hl);
                end
            end
            held = 1'b0;
            if (m_valid && m_ready) begin
                total++;
                if (m_lane !== LCW'(expLane) || m_last !== (expLane == L - 1)) begin
                    bad++; $display("[TB] FAIL rd_lane: got lane=%0d last=%b want lane=%0d last=%b",
                        m_lane, m_last, expLane, expLane == L - 1);
                end
                total++;
                if (m_data !== refMem[addr][expLane]) begin
                    bad++; $display("[TB] FAIL rd_data lane %0d: got %0h want %0h", expLane, m_data, refMem[addr][expLane]);
                end
                expLane++;
            end else if (m_valid) begin
                held = 1'b1; hd = m_data; hl = m_lane;
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        total++;
        if (expLane != L) begin bad++; $display("[TB] FAIL rd_count: got %0d handshakes want %0d", expLane, L); end
        total++;
        if (firstValid != 2 + RL) begin
            bad++; $display("[TB] FAIL rd_latency: got %0d want %0d", firstValid, 2 + RL);
        end
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL rd_done: got m_valid=%b busy=%b want 0 0", m_valid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_framing_error(input logic [A-1:0] addr);
        bit ok; int f, l, weBefore, errBefore;
        int lastPos [3] = '{10, 0, 99};
        int nBeats [3] = '{11, 1, L};
        weBefore = weCount; errBefore = errCount;
        for (int c = 0; c < 3; c++) begin
            fill_elem(1'b0);
            drive_beats(addr, lastPos[c], nBeats[c], ok, f, l);
            @(negedge clk);
            total++;
            if ({ok, err, busy, ram_we} !== 4'b1100) begin
                bad++; $display("[TB] FAIL frame_err case %0d: got ok/err/busy/we=%b want 1100",
                    c, {ok, err, busy, ram_we});
            end
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if (err !== 1'b0) begin bad++; $display("[TB] FAIL frame_err_pulse case %0d: got 1 want 0", c); end
            @(posedge clk); #1;
        end
        total++;
        if (weCount != weBefore || errCount - errBefore != 3) begin
            bad++; $display("[TB] FAIL frame_counts: got we=%0d err=%0d want 0 3",
                weCount - weBefore, errCount - errBefore);
        end
        test_load(addr + 8'h01, 1'b0);
        test_readback(addr + 8'h01, 2);
    endtask

    task automatic test_collision(input logic [A-1:0] addr);
        bit ok; int f, l, leakBefore;
        fill_elem(1'b0);
        rd_req_valid = 1'b1; rd_req_addr = addr; watchRd = 1'b1; leakBefore = rdLeak;
        drive_beats(addr, L-1, L, ok, f, l);
        @(negedge clk);
        total++;
        if (ok !== 1'b1 || ram_we !== 1'b1 || ram_waddr !== addr) begin
            bad++; $display("[TB] FAIL collide_write: got ok=%b we=%b waddr=%0h want 1 1 %0h", ok, ram_we, ram_waddr, addr);
        end
        @(posedge clk); #1;
        watchRd = 1'b0;
        total++;
        if (rdLeak != leakBefore) begin
            bad++; $display("[TB] FAIL collide_rd_ready: got %0d cycles high want 0", rdLeak - leakBefore);
        end
        for (int k = 0; k < L; k++) refMem[addr][k] = elem[k];
        test_readback(addr, 0);
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2; int f1, l1, f2, l2, badLanes;
        fill_elem(1'b0);
        drive_beats(8'h30, L-1, L, ok1, f1, l1);
        @(negedge clk);
        total++;
        if (ram_we !== 1'b1 || ram_waddr !== 8'h30) begin
            bad++; $display("[TB] FAIL b2b_first: got we=%b waddr=%0h want 1 30", ram_we, ram_waddr);
        end
        for (int k = 0; k < L; k++) refMem[8'h30][k] = elem[k];
        fill_elem(1'b0);
        drive_beats(8'h31, L-1, L, ok2, f2, l2);
        total++;
        if (!ok1 || !ok2 || f2 - l1 != 2 || l2 - f2 != L - 1) begin
            bad++; $display("[TB] FAIL b2b_timing: got gap=%0d span=%0d want 2 %0d", f2 - l1, l2 - f2, L - 1);
        end
        @(negedge clk);
        badLanes = 0;
        for (int k = 0; k < L; k++) if (ram_wdata[k*W +: W] !== elem[k]) badLanes++;
        total++;
        if (ram_we !== 1'b1 || ram_waddr !== 8'h31 || badLanes != 0) begin
            bad++; $display("[TB] FAIL b2b_second: got we=%b waddr=%0h badLanes=%0d want 1 31 0", ram_we, ram_waddr, badLanes);
        end
        for (int k = 0; k < L; k++) refMem[8'h31][k] = elem[k];
        @(posedge clk); #1;
        test_readback(8'h30, 1);
        test_readback(8'h31, 2);
    endtask

    task automatic test_reset_midload();
        bit ok; int f, l, weBefore;
        fill_elem(1'b0);
        weBefore = weCount;
        drive_beats(8'h06, 99, 7, ok, f, l);
        rst = 1'b1; s_valid = 1'b1; s_data = rand_word();
        @(negedge clk);
        total++;
        if ({s_ready, rd_req_ready, ram_we, ram_re, m_valid, busy, err} !== 7'h00 || m_lane !== '0) begin
            bad++; $display("[TB] FAIL midreset_outputs: got %b lane=%0d want 0000000 0",
                {s_ready, rd_req_ready, ram_we, ram_re, m_valid, busy, err}, m_lane);
        end
        total++;
        if (ram_wdata !== '0 || m_data !== '0) begin bad++; $display("[TB] FAIL midreset_data: got nonzero want 0"); end
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset_idle: got s_ready=%b busy=%b want 1 0", s_ready, busy);
        end
        @(posedge clk); #1;
        total++;
        if (weCount != weBefore) begin bad++; $display("[TB] FAIL midreset_no_we: got %0d want 0", weCount - weBefore); end
        test_load(8'h06, 1'b0);
        test_readback(8'h06, 0);
    endtask

    task automatic test_lanes12();
        logic [W-1:0] e12 [L2];
        bit acc; int missed, badLanes;
        missed = 0;
        for (int i = 0; i < L2; i++) begin
            e12[i] = rand_word();
            b_s_valid = 1'b1; b_s_data = e12[i];
            b_s_addr = (i == 0) ? 8'h06 : A'($urandom); b_s_last = (i == L2 - 1);
            @(negedge clk); acc = b_s_ready;
            @(posedge clk); #1;
            if (!acc) missed++;
        end
        b_s_valid = 1'b0; b_s_last = 1'b0;
        @(negedge clk);
        badLanes = 0;
        for (int k = 0; k < L2; k++) if (b_ram_wdata[k*W +: W] !== e12[k]) badLanes++;
        total++;
        if (missed != 0 || b_ram_we !== 1'b1 || b_ram_waddr !== 8'h06 || badLanes != 0) begin
            bad++; $display("[TB] FAIL l12_write: got missed=%0d we=%b waddr=%0h badLanes=%0d want 0 1 06 0",
                missed, b_ram_we, b_ram_waddr, badLanes);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (b_ram_we !== 1'b0 || b_busy !== 1'b0 || b_err !== 1'b0) begin
            bad++; $display("[TB] FAIL l12_after: got we=%b busy=%b err=%b want 0 0 0", b_ram_we, b_busy, b_err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_valid = 1'b0; s_data = '0; s_addr = '0; s_last = 1'b0;
        rd_req_valid = 1'b0; rd_req_addr = '0; m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_data = '0; b_s_addr = '0; b_s_last = 1'b0;
        test_reset();
        test_load(8'h05, 1'b1);
        test_readback(8'h05, 0);
        test_readback(8'h05, 1);
        test_framing_error(8'h21);
        test_collision(8'h40);
        test_back_to_back();
        test_reset_midload();
        test_lanes12();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
